// File: rtl/requant_chan.sv
// requant_chan
//   Per-channel complex requantizer between the FFT and the packetizer.
//   Each {re, im} sample is multiplied by the gain of its channel, scaled
//   down to OUTPUT_WIDTH with truncate-toward-zero or round-half-away-from-zero,
//   and clamped symmetrically to +/-(2**(OW-1)-1). Latency is 4 ce cycles.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   ce                pipeline / channel counter advance enable
//   data_in           {re, im} signed input, INPUT_WIDTH each
//   sync_in           marks channel 0 of a spectrum (sampled when ce)
//   round_mode        0 = truncate toward zero, 1 = round half away from zero
//   gain_we/waddr/wdata  gain table write port (ignores ce)
//   ovfl_clr          clears ovfl_count (wins over a coincident increment)
//   data_out          {re, im} signed output, OUTPUT_WIDTH each
//   sync_out, addr    sync and channel index aligned with data_out
//   ovfl              either component of data_out was clamped
//   ovfl_count        saturating count of clamped output samples
module requant_chan #(
  parameter int INPUT_WIDTH  = 18,
  parameter int OUTPUT_WIDTH = 8,
  parameter int GAIN_WIDTH   = 16,
  parameter int GAIN_FRAC    = 8,
  parameter int CHANNELS     = 2048,
  localparam int AW          = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic [2*INPUT_WIDTH-1:0]  data_in,
  input  logic                      sync_in,
  input  logic                      round_mode,
  input  logic                      gain_we,
  input  logic [AW-1:0]             gain_waddr,
  input  logic [GAIN_WIDTH-1:0]     gain_wdata,
  input  logic                      ovfl_clr,
  output logic [2*OUTPUT_WIDTH-1:0] data_out,
  output logic                      sync_out,
  output logic [AW-1:0]             addr,
  output logic                      ovfl,
  output logic [31:0]               ovfl_count
);

  localparam int IW   = INPUT_WIDTH;
  localparam int OW   = OUTPUT_WIDTH;
  localparam int GW   = GAIN_WIDTH;
  localparam int PW   = IW + GW + 1;
  localparam int SW   = PW + 1;
  localparam int SH   = GAIN_FRAC + IW - OW;
  localparam int MAXO = 2**(OW-1) - 1;
  localparam logic [GW-1:0] GAIN_ONE = GW'(1 << GAIN_FRAC);
  localparam logic [SW-1:0] RND      = SW'(1) << (SH-1);

  // Channel counter
  logic [AW-1:0] ch, ch_next;
  assign ch = sync_in ? '0 : ch_next;

  always_ff @(posedge clk) begin
    if (rst)
      ch_next <= '0;
    else if (ce)
      ch_next <= (ch == AW'(CHANNELS-1)) ? '0 : ch + 1'b1;
  end

  // Gain table. Entries are stored XOR-ed with 1.0 so an all-zero power-up
  // memory reads back as unity gain without needing an init pass.
  // Read-before-write ordering gives the old gain on a same-cycle collision.
  logic [GW-1:0] gain_mem [CHANNELS];
  logic [GW-1:0] s1_gain_raw;

  always_ff @(posedge clk) begin
    if (gain_we)
      gain_mem[gain_waddr] <= gain_wdata ^ GAIN_ONE;
    if (ce)
      s1_gain_raw <= gain_mem[ch];
  end

  // S1: input register
  logic signed [IW-1:0] s1_re, s1_im;
  logic [AW-1:0]        s1_ch;
  logic                 s1_sync;
  logic signed [GW:0]   s1_gain;
  assign s1_gain = $signed({1'b0, s1_gain_raw ^ GAIN_ONE});

  // S2: products
  logic signed [PW-1:0] s2_re, s2_im;
  logic [AW-1:0]        s2_ch;
  logic                 s2_sync;

  // S3: scaled, rounded, saturated
  logic [OW-1:0]        s3_re, s3_im;
  logic                 s3_ovfl;
  logic [AW-1:0]        s3_ch;
  logic                 s3_sync;

  // Returns {clamped, value}. Works on the magnitude so both rounding modes
  // are symmetric about zero; the sign is restored after clamping, which
  // keeps -2**(OW-1) unreachable.
  function automatic logic [OW:0] requant(input logic signed [PW-1:0] p,
                                          input logic rm);
    logic [PW-1:0] mag;
    logic [SW-1:0] sum;
    logic [SW-1:0] q;
    logic [OW-1:0] v;
    logic          clamp;
    mag   = p[PW-1] ? (~p + 1'b1) : p;
    sum   = {1'b0, mag} + (rm ? RND : '0);
    q     = sum >> SH;
    clamp = (q > SW'(MAXO));
    v     = clamp ? OW'(MAXO) : q[OW-1:0];
    if (p[PW-1])
      v = -v;
    return {clamp, v};
  endfunction

  logic [OW:0] rq_re, rq_im;
  always_comb begin
    rq_re = requant(s2_re, round_mode);
    rq_im = requant(s2_im, round_mode);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_re    <= '0;
      s1_im    <= '0;
      s1_ch    <= '0;
      s1_sync  <= 1'b0;
      s2_re    <= '0;
      s2_im    <= '0;
      s2_ch    <= '0;
      s2_sync  <= 1'b0;
      s3_re    <= '0;
      s3_im    <= '0;
      s3_ovfl  <= 1'b0;
      s3_ch    <= '0;
      s3_sync  <= 1'b0;
      data_out <= '0;
      ovfl     <= 1'b0;
      addr     <= '0;
      sync_out <= 1'b0;
    end else if (ce) begin
      s1_re    <= $signed(data_in[2*IW-1:IW]);
      s1_im    <= $signed(data_in[IW-1:0]);
      s1_ch    <= ch;
      s1_sync  <= sync_in;
      s2_re    <= PW'(s1_re) * PW'(s1_gain);
      s2_im    <= PW'(s1_im) * PW'(s1_gain);
      s2_ch    <= s1_ch;
      s2_sync  <= s1_sync;
      s3_re    <= rq_re[OW-1:0];
      s3_im    <= rq_im[OW-1:0];
      s3_ovfl  <= rq_re[OW] | rq_im[OW];
      s3_ch    <= s2_ch;
      s3_sync  <= s2_sync;
      data_out <= {s3_re, s3_im};
      ovfl     <= s3_ovfl;
      addr     <= s3_ch;
      sync_out <= s3_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || ovfl_clr)
      ovfl_count <= '0;
    else if (ce && s3_ovfl && (ovfl_count != '1))
      ovfl_count <= ovfl_count + 32'd1;
  end

endmodule

// File: tb/tb_requant_chan.sv
// tb_requant_chan
//   Directed bench for requant_chan with CHANNELS=8 (IW=18, OW=8, SH=18).
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_requant_chan;

  localparam int IW = 18;
  localparam int OW = 8;
  localparam int GW = 16;
  localparam int AW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              ce;
  logic [2*IW-1:0]   data_in;
  logic              sync_in;
  logic              round_mode;
  logic              gain_we;
  logic [AW-1:0]     gain_waddr;
  logic [GW-1:0]     gain_wdata;
  logic              ovfl_clr;
  logic [2*OW-1:0]   data_out;
  logic              sync_out;
  logic [AW-1:0]     addr;
  logic              ovfl;
  logic [31:0]       ovfl_count;

  int total = 0;
  int bad   = 0;

  requant_chan #(
    .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .GAIN_WIDTH(GW),
    .GAIN_FRAC(8), .CHANNELS(8)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .data_in(data_in), .sync_in(sync_in),
    .round_mode(round_mode), .gain_we(gain_we), .gain_waddr(gain_waddr),
    .gain_wdata(gain_wdata), .ovfl_clr(ovfl_clr), .data_out(data_out),
    .sync_out(sync_out), .addr(addr), .ovfl(ovfl), .ovfl_count(ovfl_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int out_re();
    return int'($signed(data_out[2*OW-1:OW]));
  endfunction

  function automatic int out_im();
    return int'($signed(data_out[OW-1:0]));
  endfunction

  task automatic push(input int re, input int im, input bit sy);
    ce      = 1'b1;
    data_in = {IW'(re), IW'(im)};
    sync_in = sy;
    @(negedge clk);
    gain_we  = 1'b0;
    ovfl_clr = 1'b0;
  endtask

  task automatic flush3();
    repeat (3) push(0, 0, 1'b0);
  endtask

  task automatic wr(input int a, input int g);
    ce         = 1'b0;
    gain_we    = 1'b1;
    gain_waddr = AW'(a);
    gain_wdata = GW'(g);
    @(negedge clk);
    gain_we = 1'b0;
  endtask

  initial begin
    int s, a, e, n, c;
    rst = 1'b1; ce = 1'b0; data_in = '0; sync_in = 1'b0; round_mode = 1'b0;
    gain_we = 1'b0; gain_waddr = '0; gain_wdata = '0; ovfl_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data", data_out, 0);
    chk("rst_sync", sync_out, 0);
    chk("rst_addr", addr, 0);
    chk("rst_ovfl", ovfl, 0);
    chk("rst_cnt", ovfl_count, 0);
    rst = 1'b0;

    // Unity gain everywhere
    for (int k = 0; k < 8; k++) wr(k, 256);

    // Basic scaling, truncate then round, latency 4
    round_mode = 1'b0;
    push(1536, -1536, 1'b1);
    push(0, 0, 1'b0);
    push(0, 0, 1'b0);
    chk("t1_lat_early", out_re(), 0);
    push(0, 0, 1'b0);
    chk("t1_trunc_re", out_re(), 1);
    chk("t1_trunc_im", out_im(), -1);
    chk("t1_trunc_ovfl", ovfl, 0);
    round_mode = 1'b1;
    push(1536, -1536, 1'b0);
    flush3();
    chk("t1_round_re", out_re(), 2);
    chk("t1_round_im", out_im(), -2);
    chk("t1_round_ovfl", ovfl, 0);

    // Saturation
    push(131071, -131072, 1'b0);
    flush3();
    chk("t2_r_re", out_re(), 127);
    chk("t2_r_im", out_im(), -127);
    chk("t2_r_ovfl", ovfl, 1);
    chk("t2_r_cnt", ovfl_count, 1);
    round_mode = 1'b0;
    push(131071, -131072, 1'b0);
    flush3();
    chk("t2_t_re", out_re(), 127);
    chk("t2_t_im", out_im(), -127);
    chk("t2_t_ovfl", ovfl, 1);
    chk("t2_t_cnt", ovfl_count, 2);

    // Per-channel gain, addr and sync alignment
    for (int k = 0; k < 8; k++) wr(k, 256 * (k + 1));
    for (int j = 0; j < 11; j++) begin
      if (j < 8) push(1024, 0, j == 0);
      else       push(0, 0, 1'b0);
      if (j >= 3) begin
        s = j - 3;
        chk("t3_re", out_re(), s + 1);
        chk("t3_addr", addr, s);
        chk("t3_sync", sync_out, s == 0);
      end
    end

    // Free wrap without sync, then a sync landing on channel 3
    for (int j = 0; j < 31; j++) begin
      push(1024, 0, (j == 0) || (j == 19));
      if (j >= 3) begin
        s = j - 3;
        a = (s < 19) ? (s % 8) : ((s - 19) % 8);
        chk("t4_addr", addr, a);
        chk("t4_re", out_re(), a + 1);
        chk("t4_sync", sync_out, (s == 0) || (s == 19));
      end
    end

    // Random ce gaps with gain rewrites, plus a read/write collision on ch 2
    for (int j = 0; j < 14; j++) begin
      if (j == 2) begin
        gain_we = 1'b1; gain_waddr = 3'd2; gain_wdata = 16'd2560;
      end
      push(1024, 0, j == 0);
      if (j >= 3) begin
        s = j - 3;
        c = s % 8;
        e = (c == 2 && s > 2) ? 10 : c + 1;
        chk("t5_re", out_re(), e);
        chk("t5_addr", addr, c);
      end
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        ce      = 1'b0;
        data_in = {IW'(131071), IW'(-131072)};
        sync_in = 1'b1;
        if (i == 0) begin
          c = $urandom_range(0, 7);
          if (c == 2) c = 5;
          gain_we = 1'b1; gain_waddr = AW'(c); gain_wdata = GW'(256 * (c + 1));
        end
        @(negedge clk);
        gain_we = 1'b0;
      end
    end

    // Overflow counter saturation, clear priority, mid-stream reset
    for (int k = 0; k < 8; k++) wr(k, 256);
    round_mode = 1'b0;
    ce = 1'b0;
    force dut.ovfl_count = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.ovfl_count;
    @(negedge clk);
    chk("t6_preload", ovfl_count, 64'hFFFF_FFFE);
    repeat (3) push(0, -131072, 1'b0);
    push(0, 0, 1'b0);
    chk("t6_cnt_max", ovfl_count, 64'hFFFF_FFFF);
    push(0, 0, 1'b0);
    push(0, 0, 1'b0);
    chk("t6_cnt_hold", ovfl_count, 64'hFFFF_FFFF);
    push(0, -131072, 1'b0);
    push(0, 0, 1'b0);
    push(0, 0, 1'b0);
    ovfl_clr = 1'b1;
    push(0, 0, 1'b0);
    chk("t6_clr_ovfl", ovfl, 1);
    chk("t6_clr_cnt", ovfl_count, 0);
    push(0, -131072, 1'b0);
    flush3();
    chk("t6_cnt_resume", ovfl_count, 1);

    repeat (4) push(1024, 0, 1'b0);
    chk("t6_pre_rst_re", out_re(), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_data", data_out, 0);
    chk("t6_rst_sync", sync_out, 0);
    chk("t6_rst_addr", addr, 0);
    chk("t6_rst_ovfl", ovfl, 0);
    chk("t6_rst_cnt", ovfl_count, 0);
    push(1024, 0, 1'b0);
    push(0, 0, 1'b0);
    push(0, 0, 1'b0);
    chk("t6_post_rst_early", out_re(), 0);
    push(0, 0, 1'b0);
    chk("t6_post_rst_re", out_re(), 1);
    chk("t6_post_rst_addr", addr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
